// File: rtl/rca_pkg.sv
// Shared constants for the byte-serial adder: slice width, FSM encodings,
// and the width derivation and legality helpers.
package rca_pkg;

  localparam int SLICE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int nslice_of(input int width);
    return width / SLICE_W;
  endfunction

  function automatic bit width_ok(input int width);
    return ((width % SLICE_W) == 0) && (width >= 2 * SLICE_W);
  endfunction

endpackage

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder slice used as the datapath of the serial adder.
module rca_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic [8:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[8];

endmodule

// File: rtl/rca_seq_adder64.sv
// Byte-serial WIDTH-bit adder: one rca_8bit slice is reused for NSLICE cycles,
// with valid/ready handshakes on the operand and result sides.
module rca_seq_adder64
  import rca_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = nslice_of(WIDTH);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("rca_seq_adder64: WIDTH must be a multiple of 8 and at least 16");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  rca_8bit u_slice (
    .A    (r_a[SLICE_W-1:0]),
    .B    (r_b[SLICE_W-1:0]),
    .Cin  (r_c),
    .Sum  (w_slice_sum),
    .Cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_c        <= cin;
            r_cnt      <= '0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          // Bytes enter at the top of r_sum so byte k settles at bit 8k.
          r_a   <= {{SLICE_W{1'b0}}, r_a[WIDTH-1:SLICE_W]};
          r_b   <= {{SLICE_W{1'b0}}, r_b[WIDTH-1:SLICE_W]};
          r_sum <= {w_slice_sum, r_sum[WIDTH-1:SLICE_W]};
          r_c   <= w_slice_cout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_cout      <= w_slice_cout;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rca_seq_adder64.sv
// Bench for rca_seq_adder64: directed cases plus randomized traffic scored
// against a 65-bit arithmetic reference.
module tb_rca_seq_adder64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [64:0] exp_q[$];
  logic [64:0] last_got = '0;
  bit drv_done = 1'b0;

  rca_seq_adder64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result handshakes complete on the next rising edge; score them here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      last_got = {cout, sum};
      if (exp_q.size() == 0) chk("extra_result", 65'd1, 65'd0);
      else chk("result", {cout, sum}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] a_i, input logic [63:0] b_i, input logic c_i);
    logic r;
    in_valid = 1'b1; a = a_i; b = b_i; cin = c_i;
    for (int k = 0; k < 300; k++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        acc_cyc = cyc;
        exp_q.push_back({1'b0, a_i} + {1'b0, b_i} + {64'd0, c_i});
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 65'd1, 65'd0);
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        edges = k;
        return;
      end
    end
    chk("valid_timeout", 65'd1, 65'd0);
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, {64'd0, out_valid}, 65'd0);
    chk({tag, "_busy_low"}, {64'd0, busy}, 65'd0);
    chk({tag, "_ir_high"}, {64'd0, in_ready}, 65'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk(tag, 65'(exp_q.size()), 65'd0);
  endtask

  initial begin
    int n;
    int c1;
    logic [63:0] ra, rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_sum_cout", {cout, sum}, 65'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {64'd0, in_ready}, 65'd1);

    // 1: carry out of all-ones plus one, latency 8
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("t1_busy", {64'd0, busy}, 65'd1);
    chk("t1_in_ready", {64'd0, in_ready}, 65'd0);
    wait_valid(n);
    chk("t1_latency", 65'(n), 65'd8);
    chk("t1_value", {cout, sum}, {1'b1, 64'h0});
    finish_hs("t1");

    // 2: full carry propagation with cin
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_valid(n);
    chk("t2_latency", 65'(n), 65'd8);
    chk("t2_value", {cout, sum}, {1'b1, 64'h0});
    finish_hs("t2");

    // 3: backpressure with in_valid pulsed while DONE
    send(64'h2, 64'h3, 1'b0);
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~k[0]; a = 64'hDEAD; b = 64'hBEEF; cin = 1'b1;
      @(posedge clk); #1;
      chk("t3_hold", {cout, sum}, {1'b0, 64'h5});
      chk("t3_ir_low", {64'd0, in_ready}, 65'd0);
      chk("t3_ov_high", {64'd0, out_valid}, 65'd1);
    end
    in_valid = 1'b0;
    finish_hs("t3");
    repeat (12) @(posedge clk);
    #1;
    chk("t3_no_phantom", {64'd0, out_valid}, 65'd0);

    // 4: reset during the 4th RUN cycle
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t4_ov", {64'd0, out_valid}, 65'd0);
    chk("t4_sum", {cout, sum}, 65'd0);
    chk("t4_busy", {64'd0, busy}, 65'd0);
    chk("t4_ir", {64'd0, in_ready}, 65'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t4_ir_rel", {64'd0, in_ready}, 65'd1);
    send(64'h2, 64'h3, 1'b0);
    wait_valid(n);
    chk("t4_value", {cout, sum}, {1'b0, 64'h5});
    finish_hs("t4");

    // 5: back-to-back with out_ready held high
    out_ready = 1'b1;
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    c1 = acc_cyc;
    send(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0);
    chk("t5_spacing", 65'(acc_cyc - c1), 65'd10);
    drain("t5_drain");
    chk("t5_value", last_got, {1'b0, 64'h0100_0100_0100_0100});
    out_ready = 1'b0;

    // 6: random traffic against the reference queue
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          if ($urandom_range(0, 7) == 0) ra = ~rb;
          send(ra, rb, 1'($urandom_range(0, 1)));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
